// File: rtl/demux12_reg.sv
// -----------------------------------------------------------------------------
// demux12_reg
// Registered 1:2 demultiplexer with valid/ready handshakes.
//
// One source stream is steered to output A (in_sel=0) or output B (in_sel=1).
// Each output has a one-entry holding register. A stalled consumer only blocks
// words aimed at its own channel. The steering choice is sampled with the word.
// A per-output counter tracks completed output handshakes. The counters wrap
// modulo 2^CNT_W.
//
// Parameters
//   WIDTH     data width of in_data / a_data / b_data
//   CNT_W     width of the per-output transfer counters
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   in_valid  source presents a word on in_data
//   in_ready  source word is accepted when in_valid & in_ready (combinational)
//   in_data   source word
//   in_sel    destination of the source word: 0 -> A, 1 -> B
//   a_valid   A holding register full
//   a_ready   A consumer takes the word when a_valid & a_ready
//   a_data    A holding register
//   b_valid   B holding register full
//   b_ready   B consumer takes the word when b_valid & b_ready
//   b_data    B holding register
//   a_count   completed A output handshakes, mod 2^CNT_W
//   b_count   completed B output handshakes, mod 2^CNT_W
// -----------------------------------------------------------------------------
module demux12_reg #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,

    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] a_data,

    output logic             b_valid,
    input  logic             b_ready,
    output logic [WIDTH-1:0] b_data,

    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count
);

    // A slot can take a new word when it is empty or its current word leaves
    // on this same edge. That makes one word per cycle per channel possible.
    logic a_room;
    logic b_room;
    logic load_a;
    logic load_b;
    logic drain_a;
    logic drain_b;

    assign a_room  = !a_valid || a_ready;
    assign b_room  = !b_valid || b_ready;

    // NOTE: in_ready depends only on the selected slot, never on in_valid.
    // A source may therefore wait for ready before raising valid without
    // forming a combinational loop.
    assign in_ready = in_sel ? b_room : a_room;

    assign load_a  = in_valid && in_ready && !in_sel;
    assign load_b  = in_valid && in_ready &&  in_sel;
    assign drain_a = a_valid && a_ready;
    assign drain_b = b_valid && b_ready;

    // Channel A holding register and transfer counter.
    // NOTE: state is updated with non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid <= 1'b0;
            a_data  <= '0;
            a_count <= '0;
        end else begin
            if (load_a) begin
                // A load wins over a simultaneous drain, so the slot stays full.
                a_valid <= 1'b1;
                a_data  <= in_data;
            end else if (drain_a) begin
                // Data is deliberately left in place when the slot empties.
                a_valid <= 1'b0;
            end
            if (drain_a) begin
                a_count <= a_count + 1'b1;
            end
        end
    end

    // Channel B holding register and transfer counter, mirror of channel A.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_valid <= 1'b0;
            b_data  <= '0;
            b_count <= '0;
        end else begin
            if (load_b) begin
                b_valid <= 1'b1;
                b_data  <= in_data;
            end else if (drain_b) begin
                b_valid <= 1'b0;
            end
            if (drain_b) begin
                b_count <= b_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_demux12_reg.sv
// -----------------------------------------------------------------------------
// tb_demux12_reg
// Self-checking bench for demux12_reg.
// The table-driven phase steps through steering, stalls and channel
// independence. Each record gives the expected in_ready and the expected
// post-edge outputs.
// The scoreboard phase drives back-to-back alternating words under random
// readies. It checks order and loss per channel.
// Hand-written sequences cover the mid-cycle asynchronous reset and the wrap of
// a narrow counter instance.
// -----------------------------------------------------------------------------
module tb_demux12_reg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 16;
    localparam int W_CNT = 4;

    logic             clk;
    logic             rst_n;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] a_data;
    logic             b_valid;
    logic             b_ready;
    logic [WIDTH-1:0] b_data;
    logic [CNT_W-1:0] a_count;
    logic [CNT_W-1:0] b_count;

    // Narrow-counter instance used for the wrap check.
    logic             w_in_valid;
    logic             w_in_ready;
    logic [WIDTH-1:0] w_in_data;
    logic             w_in_sel;
    logic             w_a_valid;
    logic             w_a_ready;
    logic [WIDTH-1:0] w_a_data;
    logic             w_b_valid;
    logic             w_b_ready;
    logic [WIDTH-1:0] w_b_data;
    logic [W_CNT-1:0] w_a_count;
    logic [W_CNT-1:0] w_b_count;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] qa[$];
    logic [WIDTH-1:0] qb[$];

    demux12_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_data   (a_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_data   (b_data),
        .a_count  (a_count),
        .b_count  (b_count)
    );

    demux12_reg #(.WIDTH(WIDTH), .CNT_W(W_CNT)) dut_w (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (w_in_valid),
        .in_ready (w_in_ready),
        .in_data  (w_in_data),
        .in_sel   (w_in_sel),
        .a_valid  (w_a_valid),
        .a_ready  (w_a_ready),
        .a_data   (w_a_data),
        .b_valid  (w_b_valid),
        .b_ready  (w_b_ready),
        .b_data   (w_b_data),
        .a_count  (w_a_count),
        .b_count  (w_b_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop if something hangs despite the bounded loops.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Called just before an active edge: any output handshake seen here
    // completes on that edge, so the oldest expected word must be presented.
    task automatic score_outputs();
        if (a_valid && a_ready) begin
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_a_extra: got word 0x%0h required none", a_data);
            end else begin
                check("sb_a_order", 64'(a_data), 64'(qa.pop_front()));
            end
        end
        if (b_valid && b_ready) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_b_extra: got word 0x%0h required none", b_data);
            end else begin
                check("sb_b_order", 64'(b_data), 64'(qb.pop_front()));
            end
        end
    endtask

    typedef struct {
        logic             iv;
        logic             is;
        logic [WIDTH-1:0] id;
        logic             ar;
        logic             br;
        logic             e_ir;
        logic             e_av;
        logic [WIDTH-1:0] e_ad;
        logic             e_bv;
        logic [WIDTH-1:0] e_bd;
        logic [CNT_W-1:0] e_ac;
        logic [CNT_W-1:0] e_bc;
    } vec_t;

    vec_t vecs[9];

    initial begin
        //             iv    is    data           ar    br    e_ir  e_av  e_ad           e_bv  e_bd           e_ac   e_bc
        // Steer one word to each side with both readies high.
        vecs[0] = '{1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0,        16'd0, 16'd0};
        vecs[1] = '{1'b1, 1'b1, 32'h12345678, 1'b1, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 32'h12345678, 16'd1, 16'd0};
        vecs[2] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 32'h12345678, 16'd1, 16'd1};
        // A stalled: the second A word is refused and 0x11 stays put.
        vecs[3] = '{1'b1, 1'b0, 32'h11,       1'b0, 1'b1, 1'b1, 1'b1, 32'h11,       1'b0, 32'h12345678, 16'd1, 16'd1};
        vecs[4] = '{1'b1, 1'b0, 32'h22,       1'b0, 1'b1, 1'b0, 1'b1, 32'h11,       1'b0, 32'h12345678, 16'd1, 16'd1};
        // B still accepts while A is stalled full.
        vecs[5] = '{1'b1, 1'b1, 32'h33,       1'b0, 1'b0, 1'b1, 1'b1, 32'h11,       1'b1, 32'h33,       16'd1, 16'd1};
        // A ready: 0x11 drains and 0x22 loads on the same edge.
        vecs[6] = '{1'b1, 1'b0, 32'h22,       1'b1, 1'b0, 1'b1, 1'b1, 32'h22,       1'b1, 32'h33,       16'd2, 16'd1};
        // B stalled full refuses 0x44; A drains and keeps its data.
        vecs[7] = '{1'b1, 1'b1, 32'h44,       1'b1, 1'b0, 1'b0, 1'b0, 32'h22,       1'b1, 32'h33,       16'd3, 16'd1};
        // in_ready follows b_ready with in_valid low; B drains.
        vecs[8] = '{1'b0, 1'b1, 32'h55,       1'b0, 1'b1, 1'b1, 1'b0, 32'h22,       1'b0, 32'h33,       16'd3, 16'd2};

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_sel     = 1'b0;
        in_data    = '0;
        a_ready    = 1'b0;
        b_ready    = 1'b0;
        w_in_valid = 1'b0;
        w_in_sel   = 1'b0;
        w_in_data  = '0;
        w_a_ready  = 1'b0;
        w_b_ready  = 1'b0;

        // Reset state.
        #1;
        check("rst_a_valid", 64'(a_valid), 64'd0);
        check("rst_b_valid", 64'(b_valid), 64'd0);
        check("rst_a_data",  64'(a_data),  64'd0);
        check("rst_b_data",  64'(b_data),  64'd0);
        check("rst_a_count", 64'(a_count), 64'd0);
        check("rst_b_count", 64'(b_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            in_valid = vecs[i].iv;
            in_sel   = vecs[i].is;
            in_data  = vecs[i].id;
            a_ready  = vecs[i].ar;
            b_ready  = vecs[i].br;
            #1;
            check($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].e_ir));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_a_valid", i), 64'(a_valid), 64'(vecs[i].e_av));
            check($sformatf("v%0d_a_data", i),  64'(a_data),  64'(vecs[i].e_ad));
            check($sformatf("v%0d_b_valid", i), 64'(b_valid), 64'(vecs[i].e_bv));
            check($sformatf("v%0d_b_data", i),  64'(b_data),  64'(vecs[i].e_bd));
            check($sformatf("v%0d_a_count", i), 64'(a_count), 64'(vecs[i].e_ac));
            check($sformatf("v%0d_b_count", i), 64'(b_count), 64'(vecs[i].e_bc));
        end

        // Throughput: 100 words alternating sel, random readies, scoreboarded.
        begin
            int sent = 0;
            int cyc  = 0;
            while (sent < 100 && cyc < 2000) begin
                @(negedge clk);
                in_valid = 1'b1;
                in_sel   = sent[0];
                in_data  = 32'hA000_0000 + 32'(sent);
                a_ready  = 1'($urandom_range(0, 1));
                b_ready  = 1'($urandom_range(0, 1));
                #1;
                score_outputs();
                if (in_ready) begin
                    if (in_sel) qb.push_back(in_data);
                    else        qa.push_back(in_data);
                    sent++;
                end
                @(posedge clk);
                cyc++;
            end
            check("tp_words_sent", 64'(sent), 64'd100);
        end
        begin
            @(negedge clk);
            in_valid = 1'b0;
            a_ready  = 1'b1;
            b_ready  = 1'b1;
            for (int k = 0; k < 20 && (qa.size() != 0 || qb.size() != 0); k++) begin
                if (k != 0) @(negedge clk);
                #1;
                score_outputs();
                @(posedge clk);
            end
            #1;
            check("tp_qa_empty", 64'(qa.size()), 64'd0);
            check("tp_qb_empty", 64'(qb.size()), 64'd0);
            check("tp_a_valid",  64'(a_valid),   64'd0);
            check("tp_b_valid",  64'(b_valid),   64'd0);
            check("tp_a_count",  64'(a_count),   64'd53);
            check("tp_b_count",  64'(b_count),   64'd52);
        end

        // Asynchronous reset mid-cycle with both slots full.
        @(negedge clk);
        in_valid = 1'b1;
        in_sel   = 1'b0;
        in_data  = 32'hAAAA_5555;
        a_ready  = 1'b0;
        b_ready  = 1'b0;
        @(negedge clk);
        in_sel   = 1'b1;
        in_data  = 32'h5555_AAAA;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("ar_pre_a_valid", 64'(a_valid), 64'd1);
        check("ar_pre_b_valid", 64'(b_valid), 64'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("ar_a_valid", 64'(a_valid), 64'd0);
        check("ar_b_valid", 64'(b_valid), 64'd0);
        check("ar_a_data",  64'(a_data),  64'd0);
        check("ar_b_data",  64'(b_data),  64'd0);
        check("ar_a_count", 64'(a_count), 64'd0);
        check("ar_b_count", 64'(b_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Wrap: 17 transfers to A on the 4-bit-counter instance.
        w_a_ready = 1'b1;
        w_b_ready = 1'b1;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            w_in_valid = (i < 17);
            w_in_sel   = 1'b0;
            w_in_data  = 32'hC0DE_0000 + 32'(i);
            #1;
            if (i < 17) check($sformatf("wr_in_ready_%0d", i), 64'(w_in_ready), 64'd1);
            @(posedge clk);
            #1;
            // After edge i, i drains have completed (word i-1 left on it).
            if (i == 15) check("wr_count_15", 64'(w_a_count), 64'd15);
            if (i == 16) check("wr_count_16", 64'(w_a_count), 64'd0);
        end
        @(negedge clk);
        w_in_valid = 1'b0;
        #1;
        check("wr_a_count", 64'(w_a_count), 64'd1);
        check("wr_a_valid", 64'(w_a_valid), 64'd0);
        check("wr_a_data",  64'(w_a_data),  64'hC0DE_0010);
        check("wr_b_count", 64'(w_b_count), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
